// File: rtl/sysref_gen_pkg.sv
// Shared types for the SYSREF/marker generator: mode select and FSM state encodings.
package sysref_gen_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_CONT  = 2'd1,
    MODE_BURST = 2'd2,
    MODE_RSVD  = 2'd3
  } sysref_mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } sysref_state_t;

endpackage

// File: rtl/sysref_pulse_gen.sv
// Programmable SYSREF/marker generator with continuous, counted-burst and phase-align support.
// Optional edge statistics counter is built when SYSREF_PULSE_GEN_STATS_EN is defined.
module sysref_pulse_gen
  import sysref_gen_pkg::*;
#(
  parameter int CNT_WIDTH   = 8,
  parameter int BURST_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CNT_WIDTH-1:0]   half_period_i,
  input  logic [1:0]             mode_i,
  input  logic [BURST_WIDTH-1:0] burst_count_i,
  input  logic                   start_i,
  input  logic                   align_i,
  output logic                   sysref_o,
  output logic                   edge_o,
  output logic                   busy_o,
  output logic [31:0]            pulse_count_o
);

  sysref_mode_t           mode;
  sysref_state_t          state_q, state_d;
  logic [CNT_WIDTH-1:0]   hp_q, hp_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [BURST_WIDTH-1:0] rem_q, rem_d;
  logic                   edge_q, edge_d;
  logic                   sysref_q, sysref_d;
  logic                   busy_q, busy_d;

  assign mode = sysref_mode_t'(mode_i);

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    edge_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Align is meaningless here; only a valid start leaves IDLE.
        if (start_i && (mode == MODE_CONT ||
                        (mode == MODE_BURST && burst_count_i != '0))) begin
          state_d = S_HIGH;
          hp_d    = half_period_i;
          cnt_d   = half_period_i;
          edge_d  = 1'b1;
          if (mode == MODE_BURST) begin
            rem_d = burst_count_i - 1'b1;
          end
        end
      end
      S_HIGH: begin
        if (align_i) begin
          hp_d  = half_period_i;
          cnt_d = half_period_i;
        end else if (cnt_q == '0) begin
          state_d = S_LOW;
          cnt_d   = hp_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_LOW: begin
        if (align_i) begin
          state_d = S_HIGH;
          hp_d    = half_period_i;
          cnt_d   = half_period_i;
          edge_d  = 1'b1;
        end else if (cnt_q == '0) begin
          // Mode is only consulted here, so a running HIGH/LOW pair always completes.
          if (mode == MODE_CONT) begin
            state_d = S_HIGH;
            cnt_d   = hp_q;
            edge_d  = 1'b1;
          end else if (mode == MODE_BURST && rem_q != '0) begin
            state_d = S_HIGH;
            cnt_d   = hp_q;
            rem_d   = rem_q - 1'b1;
            edge_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    sysref_d = (state_d == S_HIGH);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hp_q     <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      edge_q   <= 1'b0;
      sysref_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hp_q     <= hp_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      edge_q   <= edge_d;
      sysref_q <= sysref_d;
      busy_q   <= busy_d;
    end
  end

  assign sysref_o = sysref_q;
  assign edge_o   = edge_q;
  assign busy_o   = busy_q;

`ifdef SYSREF_PULSE_GEN_STATS_EN
  logic [31:0] pulse_cnt_q, pulse_cnt_d;

  // Counts alongside edge_d so the total already includes the edge being presented.
  always_comb begin
    pulse_cnt_d = pulse_cnt_q + {31'd0, edge_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_cnt_q <= '0;
    end else begin
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign pulse_count_o = pulse_cnt_q;
`else
  assign pulse_count_o = '0;
`endif

endmodule

// File: tb/tb_sysref_pulse_gen.sv
// Scoreboard bench for sysref_pulse_gen: a period/phase-position reference model predicts
// every cycle's outputs; a monitor pops and compares them one posedge later.
module tb_sysref_pulse_gen;

  typedef struct {
    logic        sysref;
    logic        edg;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

`ifdef SYSREF_PULSE_GEN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  half_period_i = '0;
  logic [1:0]  mode_i = '0;
  logic [7:0]  burst_count_i = '0;
  logic        start_i = 1'b0;
  logic        align_i = 1'b0;
  logic        sysref_o;
  logic        edge_o;
  logic        busy_o;
  logic [31:0] pulse_count_o;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // Reference model: running flag, position inside the current period, pulses left.
  bit          m_run = 1'b0;
  int          m_pos = 0;
  int          m_per = 1;
  int          m_left = 0;
  bit          m_edge = 1'b0;
  logic [31:0] m_cnt = '0;
  bit          preload_req = 1'b0;

  logic [1:0]  cur_mode = 2'd0;
  logic [7:0]  cur_hp = 8'd0;
  logic [7:0]  cur_bc = 8'd0;

  sysref_pulse_gen #(.CNT_WIDTH(8), .BURST_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .half_period_i (half_period_i),
    .mode_i        (mode_i),
    .burst_count_i (burst_count_i),
    .start_i       (start_i),
    .align_i       (align_i),
    .sysref_o      (sysref_o),
    .edge_o        (edge_o),
    .busy_o        (busy_o),
    .pulse_count_o (pulse_count_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, advance the model, queue what the DUT must show next.
  task automatic applyStimulus(input logic r, input logic st, input logic al);
    exp_t e;
    @(negedge clk);
    rst           = r;
    start_i       = st;
    align_i       = al;
    mode_i        = cur_mode;
    half_period_i = cur_hp;
    burst_count_i = cur_bc;
`ifdef SYSREF_PULSE_GEN_STATS_EN
    if (preload_req) begin
      force dut.pulse_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.pulse_cnt_q;
      m_cnt = 32'hFFFF_FFFF;
      preload_req = 1'b0;
    end
`endif
    if (r) begin
      m_run = 1'b0; m_pos = 0; m_left = 0; m_cnt = '0; m_edge = 1'b0;
    end else if (!m_run) begin
      m_edge = 1'b0;
      if (st && (cur_mode == 2'd1 || (cur_mode == 2'd2 && cur_bc != 0))) begin
        m_run = 1'b1; m_per = int'(cur_hp) + 1; m_pos = 0; m_edge = 1'b1;
        if (cur_mode == 2'd2) m_left = int'(cur_bc) - 1;
      end
    end else if (al) begin
      m_edge = (m_pos >= m_per);
      m_per  = int'(cur_hp) + 1;
      m_pos  = 0;
    end else begin
      m_edge = 1'b0;
      m_pos++;
      if (m_pos == 2 * m_per) begin
        if (cur_mode == 2'd1) begin
          m_pos = 0; m_edge = 1'b1;
        end else if (cur_mode == 2'd2 && m_left != 0) begin
          m_left--; m_pos = 0; m_edge = 1'b1;
        end else begin
          m_run = 1'b0; m_pos = 0;
        end
      end
    end
    if (m_edge) m_cnt = m_cnt + 32'd1;
    e.sysref = m_run && (m_pos < m_per);
    e.edg    = m_edge;
    e.busy   = m_run;
    e.cnt    = STATS ? m_cnt : 32'd0;
    exp_q.push_back(e);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: the DUT presents a new output set every cycle; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("sysref_o", {31'd0, sysref_o}, {31'd0, e.sysref});
        checkOutput("edge_o", {31'd0, edge_o}, {31'd0, e.edg});
        checkOutput("busy_o", {31'd0, busy_o}, {31'd0, e.busy});
        checkOutput("pulse_count_o", pulse_count_o, e.cnt);
      end
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    runCycles(6);

    // Continuous, 24-cycle half period, then align in LOW, align mid-HIGH, then switch OFF.
    cur_mode = 2'd1; cur_hp = 8'd23;
    applyStimulus(1'b0, 1'b1, 1'b0);
    runCycles(110);
    for (guard = 0; guard < 200 && !(m_run && m_pos == m_per + 4); guard++) runCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    runCycles(10);
    applyStimulus(1'b0, 1'b0, 1'b1);
    runCycles(30);
    for (guard = 0; guard < 200 && !(m_run && m_pos == 3); guard++) runCycles(1);
    cur_mode = 2'd0;
    runCycles(60);

    // Burst of three 2-high/2-low pulses, then a zero-length burst that must be ignored.
    cur_mode = 2'd2; cur_hp = 8'd1; cur_bc = 8'd3;
    applyStimulus(1'b0, 1'b1, 1'b0);
    runCycles(16);
    cur_bc = 8'd0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    runCycles(5);

    // clk/2 square wave with a reset dropped in mid-HIGH.
    cur_mode = 2'd1; cur_hp = 8'd0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    runCycles(5);
    for (guard = 0; guard < 10 && !(m_run && m_pos < m_per); guard++) runCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    runCycles(4);

    // Wrap of the edge counter from all-ones to zero.
    cur_hp = 8'd2; cur_mode = 2'd1;
    preload_req = STATS;
    runCycles(2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    runCycles(8);
    cur_mode = 2'd0;
    runCycles(10);

    // Randomised stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) cur_mode = 2'($urandom_range(3));
      if ($urandom_range(24) == 0) cur_hp = 8'($urandom_range(6));
      if ($urandom_range(24) == 0) cur_bc = 8'($urandom_range(4));
      applyStimulus($urandom_range(499) == 0, $urandom_range(19) == 0, $urandom_range(29) == 0);
    end
    runCycles(2);

    for (guard = 0; guard < 10 && exp_q.size() > 0; guard++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysref_pulse_gen.md
# sysref_pulse_gen

Parametrised SYSREF/marker generator for the RFSoC ADC fabric clock domain. It replaces the fixed divide-and-toggle fake SYSREF with runtime-programmable period, continuous or counted-burst modes, and phase re-alignment to an in-domain strobe such as a PPS flag already synchronised to `aclk`. Its output drives the user SYSREF input of the RF data converter and any fabric logic that needs the same marker.

## Interface

Parameters:
- `CNT_WIDTH`, 8: width of the half-period counter and of `half_period_i`.
- `BURST_WIDTH`, 8: width of `burst_count_i` and of the remaining-pulse counter.

Ports:
- `clk`  in  1  ADC AXI4-Stream clock. Single clock domain for the whole block.
- `rst`  in  1  synchronous, active-high reset.
- `half_period_i`  in  CNT_WIDTH  half-period length minus 1, in `clk` cycles. The period is 2·(value+1).
- `mode_i`  in  2  mode select: 0 OFF, 1 CONTINUOUS, 2 BURST, 3 reserved (treated as OFF).
- `burst_count_i`  in  BURST_WIDTH  number of pulses in a BURST. A value of 0 means the start is ignored.
- `start_i`  in  1  single-cycle start strobe.
- `align_i`  in  1  single-cycle phase-restart strobe.
- `sysref_o`  out  1  registered SYSREF output.
- `edge_o`  out  1  one-cycle strobe in the cycle where `sysref_o` rises.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `pulse_count_o`  out  32  count of rising edges since reset.

## Operation

- States: IDLE, HIGH, LOW. `sysref_o` = (state == HIGH), registered.
- `half_period_i` is latched into `hp_q` on any accepted start or align. The down-counter loads `hp_q` on each state entry.
- IDLE → HIGH on `start_i` when:
  - mode is CONTINUOUS, or
  - mode is BURST and `burst_count_i` ≠ 0.
  - In BURST, also latch `remaining = burst_count_i − 1`.
  - Otherwise the start is ignored.
- HIGH → LOW when the counter reaches 0, i.e. after `hp_q`+1 cycles.
- At the end of LOW, when the counter reaches 0:
  - CONTINUOUS: go to HIGH.
  - BURST with `remaining` ≠ 0: decrement `remaining` and go to HIGH.
  - BURST with `remaining` = 0: go to IDLE.
  - `mode_i` OFF or reserved: go to IDLE.
- A mode change takes effect only at the LOW→next decision. A HIGH phase is never truncated by a mode change.
- `align_i` while HIGH or LOW: next state is HIGH with the counter reloaded and `hp_q` re-latched. `remaining` is unchanged.
  - If the current state is HIGH, the HIGH phase restarts; `edge_o` does not fire.
  - If the current state is LOW, `sysref_o` rises next cycle and `edge_o` fires.
- `align_i` in IDLE is ignored.
- Simultaneous `start_i` and `align_i`:
  - In IDLE, the start wins.
  - While running, the start is ignored and the align applies.
- Changes to `half_period_i` while running take effect only at the next start or align.
- `pulse_count_o` increments on every `edge_o` and wraps from 2^32−1 to 0.

## Timing

- Reset values: `sysref_o`=0, `edge_o`=0, `busy_o`=0, `pulse_count_o`=0, state IDLE, counters 0.
- Start latency: `start_i` in cycle N gives `sysref_o`=1, `edge_o`=1 and `busy_o`=1 in cycle N+1.
- Align latency: `align_i` in cycle N during LOW gives `sysref_o`=1 in cycle N+1.
- `busy_o` falls in the cycle after the last LOW cycle of a finished run.
- `rst` mid-run forces all reset values in the next cycle, regardless of other inputs.
- `half_period_i`=0 gives a 1-high / 1-low square wave (`clk`/2).

## Configuration

- `SYSREF_PULSE_GEN_STATS_EN` defined: the 32-bit edge counter is built and drives `pulse_count_o`.
- Not defined: the counter is not built and `pulse_count_o` is tied to 0. The port stays in the port list.

## Structure

- Package `sysref_gen_pkg` holds:
  - `sysref_mode_t`, a 2-bit enum: MODE_OFF, MODE_CONT, MODE_BURST, MODE_RSVD.
  - `sysref_state_t`: S_IDLE, S_HIGH, S_LOW.
- No sub-module. The FSM, the half-period counter, the burst counter and the optional stats counter live in one module.

## Test plan

- CONTINUOUS, `half_period_i`=23, start at cycle 10 → `sysref_o` high for cycles 11–34, low for 35–58, high again at 59. `edge_o` fires every 48 cycles.
- BURST, `burst_count_i`=3, `half_period_i`=1, start → three 2-cycle-high pulses, 4-cycle period. `busy_o` falls 12 cycles after `sysref_o` first rises. `pulse_count_o`=3.
- CONTINUOUS, `half_period_i`=23, `align_i` on the 5th LOW cycle → `sysref_o`=1 next cycle with a full 24-cycle HIGH. `align_i` mid-HIGH → HIGH lasts 24 cycles from the align, with no extra `edge_o`.
- CONTINUOUS, switch `mode_i` to OFF during HIGH → the current HIGH and LOW complete, then IDLE with `busy_o`=0.
- BURST, `burst_count_i`=0, start → `sysref_o` and `busy_o` stay 0. `rst` asserted mid-HIGH → all outputs 0 on the next cycle.
- Stats: force 2^32−1 edges (preload in the bench) plus one edge → `pulse_count_o`=0. Without the macro, `pulse_count_o` stays 0 throughout.
